// File: rtl/hh_pkg.sv
// Shared Q8.8 constants, FSM encoding, step indices and saturation helpers
// for the Hodgkin-Huxley current scheduler.
package hh_pkg;

  localparam int DW   = 16;
  localparam int FRAC = 8;

  localparam logic [15:0] Q_ONE = 16'h0100;
  localparam logic [15:0] Q_MAX = 16'h7FFF;
  localparam logic [15:0] Q_MIN = 16'h8000;

  localparam logic [15:0] G_K_DEF  = 16'h2400;
  localparam logic [15:0] E_K_DEF  = 16'hF400;
  localparam logic [15:0] G_NA_DEF = 16'h7800;
  localparam logic [15:0] E_NA_DEF = 16'h7300;
  localparam logic [15:0] G_L_DEF  = 16'h004D;
  localparam logic [15:0] E_L_DEF  = 16'h0A9A;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SUM  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Multiply issued in each RUN step; STEP_FLUSH only collects the last product.
  localparam logic [3:0] STEP_NN    = 4'd0;
  localparam logic [3:0] STEP_N4    = 4'd1;
  localparam logic [3:0] STEP_GK    = 4'd2;
  localparam logic [3:0] STEP_IK    = 4'd3;
  localparam logic [3:0] STEP_MM    = 4'd4;
  localparam logic [3:0] STEP_M3    = 4'd5;
  localparam logic [3:0] STEP_MH    = 4'd6;
  localparam logic [3:0] STEP_GNA   = 4'd7;
  localparam logic [3:0] STEP_INA   = 4'd8;
  localparam logic [3:0] STEP_IL    = 4'd9;
  localparam logic [3:0] STEP_FLUSH = 4'd10;

  function automatic logic signed [17:0] ext18(input logic [DW-1:0] x);
    return $signed({{2{x[DW-1]}}, x});
  endfunction

  function automatic logic [DW-1:0] sat_clamp(input logic signed [17:0] x);
    logic [DW-1:0] r;
    if (x > 18'sd32767) r = Q_MAX;
    else if (x < -18'sd32768) r = Q_MIN;
    else r = x[DW-1:0];
    return r;
  endfunction

  function automatic logic sat_flag(input logic signed [17:0] x);
    return (x > 18'sd32767) || (x < -18'sd32768);
  endfunction

  function automatic logic [DW-1:0] sat_add3(input logic [DW-1:0] a,
                                             input logic [DW-1:0] b,
                                             input logic [DW-1:0] c);
    return sat_clamp(ext18(a) + ext18(b) + ext18(c));
  endfunction

endpackage

// File: rtl/hh_fxp_mul.sv
// Registered saturating signed Q8.8 multiplier, one-cycle latency.
// Overflow output present only when HH_OVF_FLAG_EN is defined.
module hh_fxp_mul
  import hh_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
`ifdef HH_OVF_FLAG_EN
  output logic          ovf,
`endif
  output logic [DW-1:0] q
);

  logic signed [31:0] prod;
  logic               fits;
  logic [DW-1:0]      res;

  // Bits 31..23 must agree for prod[23:8] to represent the product exactly.
  always_comb begin
    prod = $signed(a) * $signed(b);
    fits = (prod[31:23] == 9'h000) || (prod[31:23] == 9'h1FF);
    if (fits) res = prod[23:8];
    else res = prod[31] ? Q_MIN : Q_MAX;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 16'h0000;
    else q <= res;
  end

`ifdef HH_OVF_FLAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf <= 1'b0;
    else ovf <= ~fits;
  end
`endif

endmodule

// File: rtl/hh_current_scheduler.sv
// Hodgkin-Huxley ionic current scheduler: ten multiplies on one shared multiplier,
// then a saturating sum. Optional sticky ovf output under HH_OVF_FLAG_EN.
module hh_current_scheduler
  import hh_pkg::*;
#(
  parameter logic [15:0] G_K  = G_K_DEF,
  parameter logic [15:0] E_K  = E_K_DEF,
  parameter logic [15:0] G_NA = G_NA_DEF,
  parameter logic [15:0] E_NA = E_NA_DEF,
  parameter logic [15:0] G_L  = G_L_DEF,
  parameter logic [15:0] E_L  = E_L_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] V,
  input  logic [DW-1:0] n,
  input  logic [DW-1:0] m,
  input  logic [DW-1:0] h,
  output logic          busy,
  output logic          done,
`ifdef HH_OVF_FLAG_EN
  output logic          ovf,
`endif
  output logic [DW-1:0] I_K,
  output logic [DW-1:0] I_NA,
  output logic [DW-1:0] I_L,
  output logic [DW-1:0] I_ION
);

  state_t        state_r, state_s;
  logic [3:0]    step_r;
  logic          accept_s;
  logic          busy_r, done_r;
  logic [DW-1:0] n_r, m_r, h_r, dk_r, dna_r, dl_r;
  logic [DW-1:0] k_r, na_r, l_r;
  logic [DW-1:0] ik_r, ina_r, il_r, iion_r;
  logic [DW-1:0] op_a_s, op_b_s, mul_q_s;
  logic signed [17:0] diff_k_s, diff_na_s, diff_l_s, sum_s;

  assign accept_s  = (state_r == ST_IDLE) && start;
  assign diff_k_s  = ext18(V) - ext18(E_K);
  assign diff_na_s = ext18(V) - ext18(E_NA);
  assign diff_l_s  = ext18(V) - ext18(E_L);
  assign sum_s     = ext18(k_r) + ext18(na_r) + ext18(l_r);

  assign busy  = busy_r;
  assign done  = done_r;
  assign I_K   = ik_r;
  assign I_NA  = ina_r;
  assign I_L   = il_r;
  assign I_ION = iion_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else state_r <= state_s;
  end

  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: if (start) state_s = ST_RUN; else state_s = ST_IDLE;
      ST_RUN:  if (step_r == STEP_FLUSH) state_s = ST_SUM; else state_s = ST_RUN;
      ST_SUM:  state_s = ST_DONE;
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Operand select; the previous registered product feeds the chained steps.
  always_comb begin
    op_a_s = 16'h0000;
    op_b_s = 16'h0000;
    if (state_r == ST_RUN) begin
      case (step_r)
        STEP_NN:  begin op_a_s = n_r;     op_b_s = n_r;   end
        STEP_N4:  begin op_a_s = mul_q_s; op_b_s = mul_q_s; end
        STEP_GK:  begin op_a_s = mul_q_s; op_b_s = G_K;   end
        STEP_IK:  begin op_a_s = mul_q_s; op_b_s = dk_r;  end
        STEP_MM:  begin op_a_s = m_r;     op_b_s = m_r;   end
        STEP_M3:  begin op_a_s = mul_q_s; op_b_s = m_r;   end
        STEP_MH:  begin op_a_s = mul_q_s; op_b_s = h_r;   end
        STEP_GNA: begin op_a_s = mul_q_s; op_b_s = G_NA;  end
        STEP_INA: begin op_a_s = mul_q_s; op_b_s = dna_r; end
        STEP_IL:  begin op_a_s = G_L;     op_b_s = dl_r;  end
        default:  begin op_a_s = 16'h0000; op_b_s = 16'h0000; end
      endcase
    end else begin
      op_a_s = 16'h0000;
      op_b_s = 16'h0000;
    end
  end

`ifdef HH_OVF_FLAG_EN
  logic mul_ovf_s;
  logic ovf_r;

  hh_fxp_mul u_mul (
    .clk (clk),
    .rst (rst),
    .a   (op_a_s),
    .b   (op_b_s),
    .ovf (mul_ovf_s),
    .q   (mul_q_s)
  );

  assign ovf = ovf_r;

  // Sticky per-step saturation flag; the product seen in step 0 belongs to the last step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_r <= 1'b0;
    else if (accept_s)
      ovf_r <= sat_flag(diff_k_s) | sat_flag(diff_na_s) | sat_flag(diff_l_s);
    else if ((state_r == ST_RUN) && (step_r != STEP_NN)) ovf_r <= ovf_r | mul_ovf_s;
    else if (state_r == ST_SUM) ovf_r <= ovf_r | sat_flag(sum_s);
    else ovf_r <= ovf_r;
  end
`else
  hh_fxp_mul u_mul (
    .clk (clk),
    .rst (rst),
    .a   (op_a_s),
    .b   (op_b_s),
    .q   (mul_q_s)
  );
`endif

  // Operand latch, partial-result capture and the single visible result update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_r <= 4'd0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      n_r <= 16'h0000; m_r <= 16'h0000; h_r <= 16'h0000;
      dk_r <= 16'h0000; dna_r <= 16'h0000; dl_r <= 16'h0000;
      k_r <= 16'h0000; na_r <= 16'h0000; l_r <= 16'h0000;
      ik_r <= 16'h0000; ina_r <= 16'h0000; il_r <= 16'h0000; iion_r <= 16'h0000;
    end else begin
      done_r <= 1'b0;
      if (accept_s) begin
        busy_r <= 1'b1;
        step_r <= 4'd0;
        n_r    <= n;
        m_r    <= m;
        h_r    <= h;
        dk_r   <= sat_clamp(diff_k_s);
        dna_r  <= sat_clamp(diff_na_s);
        dl_r   <= sat_clamp(diff_l_s);
      end else if (state_r == ST_RUN) begin
        step_r <= step_r + 4'd1;
        if (step_r == STEP_MM) k_r <= mul_q_s;
        if (step_r == STEP_IL) na_r <= mul_q_s;
        if (step_r == STEP_FLUSH) l_r <= mul_q_s;
      end else if (state_r == ST_SUM) begin
        done_r <= 1'b1;
        ik_r   <= k_r;
        ina_r  <= na_r;
        il_r   <= l_r;
        iion_r <= sat_add3(k_r, na_r, l_r);
      end else if (state_r == ST_DONE) begin
        busy_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hh_current_scheduler.sv
// Directed table-driven bench: one instance with unit conductances / zero reversals,
// one with default constants; plus sequences for reset abort, start filtering, input wiggle.
module tb_hh_current_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] v = 16'h0000, n = 16'h0000, m = 16'h0000, h = 16'h0000;
  logic        busy_u, done_u, busy_d, done_d;
  logic [15:0] ik_u, ina_u, il_u, iion_u, ik_d, ina_d, il_d, iion_d;
`ifdef HH_OVF_FLAG_EN
  logic        ovf_u, ovf_d;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hh_current_scheduler #(
    .G_K(16'h0100), .E_K(16'h0000), .G_NA(16'h0100),
    .E_NA(16'h0000), .G_L(16'h0100), .E_L(16'h0000)
  ) u_unit (
    .clk(clk), .rst(rst), .start(start), .V(v), .n(n), .m(m), .h(h),
    .busy(busy_u), .done(done_u),
`ifdef HH_OVF_FLAG_EN
    .ovf(ovf_u),
`endif
    .I_K(ik_u), .I_NA(ina_u), .I_L(il_u), .I_ION(iion_u)
  );

  hh_current_scheduler u_dflt (
    .clk(clk), .rst(rst), .start(start), .V(v), .n(n), .m(m), .h(h),
    .busy(busy_d), .done(done_d),
`ifdef HH_OVF_FLAG_EN
    .ovf(ovf_d),
`endif
    .I_K(ik_d), .I_NA(ina_d), .I_L(il_d), .I_ION(iion_d)
  );

  typedef struct {
    logic        dflt;
    logic [15:0] v, n, m, h;
    logic [15:0] ik, ina, il, iion;
    logic        ovf;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one step and wait for done; lat = cycles after the accepting edge, -1 on timeout.
  task automatic run_step(input logic [15:0] vv, nn, mm, hh, input bit wiggle, output int lat);
    @(negedge clk);
    v = vv; n = nn; m = mm; h = hh; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clk);
      if (done_u) lat = k;
      else if (wiggle) begin
        v = 16'($urandom); n = 16'($urandom); m = 16'($urandom); h = 16'($urandom);
      end
    end
  endtask

  initial begin
    int lat, first, second, cnt;

    tbl[0] = '{1'b0, 16'h0200, 16'h0080, 16'h0080, 16'h0100, 16'h0020, 16'h0040, 16'h0200, 16'h0260, 1'b0};
    tbl[1] = '{1'b0, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0300, 1'b0};
    tbl[2] = '{1'b0, 16'hFF00, 16'h0100, 16'h0080, 16'h0080, 16'hFF00, 16'hFFF0, 16'hFF00, 16'hFDF0, 1'b0};
    tbl[3] = '{1'b0, 16'h7000, 16'h0100, 16'h0100, 16'h0100, 16'h7000, 16'h7000, 16'h7000, 16'h7FFF, 1'b1};
    tbl[4] = '{1'b0, 16'h8000, 16'h0100, 16'h0100, 16'h0100, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b1};
    tbl[5] = '{1'b1, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 16'hFCCF, 16'h7CCE, 1'b1};
    tbl[6] = '{1'b1, 16'hF400, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hF933, 16'hF933, 1'b0};
    tbl[7] = '{1'b1, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hD980, 16'hD980, 1'b1};

    repeat (3) @(negedge clk);
    check("reset busy", {31'd0, busy_u | busy_d}, 32'd0);
    check("reset done", {31'd0, done_u | done_d}, 32'd0);
    check("reset I_ION", {16'd0, iion_u | iion_d}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_step(tbl[i].v, tbl[i].n, tbl[i].m, tbl[i].h, 1'b0, lat);
      check($sformatf("v%0d latency", i), lat, 32'd12);
      check($sformatf("v%0d busy at done", i), {31'd0, busy_u}, 32'd1);
      check($sformatf("v%0d I_K", i), {16'd0, tbl[i].dflt ? ik_d : ik_u}, {16'd0, tbl[i].ik});
      check($sformatf("v%0d I_NA", i), {16'd0, tbl[i].dflt ? ina_d : ina_u}, {16'd0, tbl[i].ina});
      check($sformatf("v%0d I_L", i), {16'd0, tbl[i].dflt ? il_d : il_u}, {16'd0, tbl[i].il});
      check($sformatf("v%0d I_ION", i), {16'd0, tbl[i].dflt ? iion_d : iion_u}, {16'd0, tbl[i].iion});
`ifdef HH_OVF_FLAG_EN
      check($sformatf("v%0d ovf", i), {31'd0, tbl[i].dflt ? ovf_d : ovf_u}, {31'd0, tbl[i].ovf});
`endif
    end
    check("I_L sign", {31'd0, il_d[15]}, 32'd1);

    // Inputs scrambled every busy cycle must not disturb the latched step.
    run_step(16'h0200, 16'h0080, 16'h0080, 16'h0100, 1'b1, lat);
    check("wiggle latency", lat, 32'd12);
    check("wiggle I_K", {16'd0, ik_u}, 32'h0020);
    check("wiggle I_NA", {16'd0, ina_u}, 32'h0040);
    check("wiggle I_L", {16'd0, il_u}, 32'h0200);
    check("wiggle I_ION", {16'd0, iion_u}, 32'h0260);

    // Start pulses at cycles 3 and 12 are dropped; cycle 13 starts a second step.
    @(negedge clk);
    v = 16'h0200; n = 16'h0080; m = 16'h0080; h = 16'h0100; start = 1'b1;
    @(posedge clk);
    first = -1; second = -1; cnt = 0;
    for (int k = 0; k <= 30; k++) begin
      @(negedge clk);
      if (done_u) begin
        cnt++;
        if (first < 0) first = k;
        else second = k;
      end
      if (k == 13) check("busy after done", {31'd0, busy_u}, 32'd0);
      start = (k == 3 || k == 12 || k == 13);
    end
    start = 1'b0;
    check("done count", cnt, 32'd2);
    check("first done cycle", first, 32'd12);
    check("second done cycle", second, 32'd26);

    // Asynchronous reset mid-step clears everything immediately and cancels the done.
    @(negedge clk);
    v = 16'h0100; n = 16'h0100; m = 16'h0100; h = 16'h0100; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort busy", {31'd0, busy_u}, 32'd0);
    check("abort done", {31'd0, done_u}, 32'd0);
    check("abort I_K", {16'd0, ik_u}, 32'd0);
    check("abort I_NA", {16'd0, ina_u}, 32'd0);
    check("abort I_L", {16'd0, il_u}, 32'd0);
    check("abort I_ION", {16'd0, iion_u}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done_u) cnt++;
    end
    check("no done after abort", cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
